// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bus between fetch_ctrl and the instruction memory / fetch decoder.
// The memory side returns the decoded fields in the same cycle as imem_ack.
interface fetch_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [63:0] val_P_reg;
    logic [3:0]  dec_code;
    logic [63:0] dec_val_P;
    logic [63:0] dec_val_C;
    logic        dec_inst_valid;

    modport master (
        output imem_req,
        output val_P_reg,
        input  imem_ack,
        input  dec_code,
        input  dec_val_P,
        input  dec_val_C,
        input  dec_inst_valid
    );

    modport slave (
        input  imem_req,
        input  val_P_reg,
        output imem_ack,
        output dec_code,
        output dec_val_P,
        output dec_val_C,
        output dec_inst_valid
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, handshakes with instruction memory and
// issues accepted instructions to decode, with branch/return redirect handling.
//
// state    | meaning
// IDLE     | stopped, PC held, waits for valid
// FETCH    | requesting imem at PC; each accept issues one instruction
// WAIT_RET | return issued, target unknown; waits for redirect_en
// HALT     | halt instruction issued; sticky until valid drops
// ERR      | illegal instruction accepted; sticky until valid drops
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [63:0]          redirect_pc,
    fetch_ctrl_if.master         imem,
    output logic                 f_valid,
    output logic [1:0]           stat,
    output logic [CNT_WIDTH-1:0] inst_cnt
);

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    localparam logic [1:0] STAT_AOK  = 2'd0;
    localparam logic [1:0] STAT_HLT  = 2'd1;
    localparam logic [1:0] STAT_INS  = 2'd2;
    localparam logic [1:0] STAT_IDLE = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_RET = 3'd2,
        HALT     = 3'd3,
        ERR      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        issue;
    logic        req;
    logic        accept;

    assign req            = (state_q == FETCH) & ~stall & ~redirect_en;
    assign accept         = req & imem.imem_ack;
    assign imem.imem_req  = req;
    assign imem.val_P_reg = pc_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            f_valid  <= 1'b0;
            inst_cnt <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            f_valid <= issue;
            if (issue) begin
                inst_cnt <= inst_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_en) begin
                    pc_d    = redirect_pc;
                    state_d = valid ? FETCH : IDLE;
                end else if (accept) begin
                    if (!imem.dec_inst_valid) begin
                        state_d = ERR;
                    end else begin
                        issue = 1'b1;
                        unique case (imem.dec_code)
                            IHALT: state_d = HALT;
                            IJXX, ICALL: begin
                                pc_d    = imem.dec_val_C;
                                state_d = valid ? FETCH : IDLE;
                            end
                            IRET: begin
                                pc_d    = imem.dec_val_P;
                                state_d = WAIT_RET;
                            end
                            default: begin
                                pc_d    = imem.dec_val_P;
                                state_d = valid ? FETCH : IDLE;
                            end
                        endcase
                    end
                end else if (!stall && !valid) begin
                    // a stalled fetch keeps its state even when asked to stop
                    state_d = IDLE;
                end
            end
            WAIT_RET: begin
                if (redirect_en) begin
                    pc_d    = redirect_pc;
                    state_d = valid ? FETCH : IDLE;
                end
            end
            HALT, ERR: begin
                if (!valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stat = STAT_IDLE;
        unique case (state_q)
            FETCH, WAIT_RET: stat = STAT_AOK;
            HALT:            stat = STAT_HLT;
            ERR:             stat = STAT_INS;
            default:         stat = STAT_IDLE;
        endcase
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0, value loaded into PC on reset.
REQ-002 Parameter CNT_WIDTH, default 32, width of inst_cnt.
REQ-003 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 valid  in  1  start/stop; 1 = run, 0 = stop after current fetch.
REQ-006 stall  in  1  hazard stall from pipeline control; holds fetch.
REQ-007 redirect_en  in  1  branch-mispredict / ret-resolve PC override.
REQ-008 redirect_pc  in  64  override target PC.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_ack  in  1  instruction-memory data valid; ignored when imem_req=0.
REQ-011 dec_code  in  4  icode from fetch decode (`ICODE field).
REQ-012 dec_val_P  in  64  sequential next PC from fetch decode.
REQ-013 dec_val_C  in  64  constant word from fetch decode.
REQ-014 dec_inst_valid  in  1  decode legality flag.
REQ-015 val_P_reg  out  64  current PC; drives fetch and imem address.
REQ-016 f_valid  out  1  one-cycle pulse: fetched instruction issued to decode.
REQ-017 stat  out  2  0=AOK, 1=HLT, 2=INS, 3=IDLE.
REQ-018 inst_cnt  out  CNT_WIDTH  count of issued instructions.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT_RET, HALT, ERR.
REQ-020 imem_req SHALL equal (state==FETCH) & ~stall & ~redirect_en, combinationally.
REQ-021 An accept SHALL occur on a cycle with imem_req=1 and imem_ack=1; imem_ack with imem_req=0 SHALL be ignored.
REQ-022 IDLE: valid=1 -> FETCH next cycle; else remain, PC held.
REQ-023 FETCH accept with dec_inst_valid=0 -> ERR, no f_valid, PC held.
REQ-024 FETCH accept with dec_code=`IHALT -> HALT, f_valid=1, PC held.
REQ-025 FETCH accept with `IJXX or `ICALL -> f_valid=1, PC <= dec_val_C (predict taken).
REQ-026 FETCH accept with `IRET -> f_valid=1, PC <= dec_val_P, state WAIT_RET.
REQ-027 FETCH accept, any other legal code -> f_valid=1, PC <= dec_val_P.
REQ-028 f_valid SHALL be registered, high exactly one cycle after each issuing accept.
REQ-029 In FETCH or WAIT_RET, redirect_en=1 SHALL load PC <= redirect_pc, suppress any accept that cycle, and go to FETCH (or IDLE if valid=0).
REQ-030 In IDLE, HALT, ERR, redirect_en SHALL be ignored.
REQ-031 WAIT_RET: no requests; leaves only via redirect_en.
REQ-032 FETCH with valid=0: state -> IDLE at the end of any cycle with no accept; an accept in the same cycle still issues first.
REQ-033 HALT/ERR SHALL be sticky; exit to IDLE only when valid=0; restart refetches from held PC.
REQ-034 stall=1 SHALL freeze PC and state in FETCH; no accept possible.
REQ-035 inst_cnt SHALL increment on each f_valid-producing accept, wrap modulo 2^CNT_WIDTH.
REQ-036 stat: FETCH/WAIT_RET=AOK, HALT=HLT, ERR=INS, IDLE=IDLE.

Reset
REQ-037 rst_n=0 SHALL immediately force: state IDLE, val_P_reg=RESET_PC, f_valid=0, inst_cnt=0, stat=3; imem_req=0.
REQ-038 Reset mid-fetch SHALL discard the outstanding request; no f_valid after release.
REQ-039 Release SHALL be synchronous to sys_clk; first FETCH one cycle after valid seen high.

Verification
REQ-040 Reset, valid=1, ack every cycle, code `IRRMOVL with val_P=PC+2 -> PC 0,2,4,6; f_valid each cycle; inst_cnt=3 after three accepts.
REQ-041 Accept `IJXX with val_C=64'h40 -> PC=64'h40 next cycle; then redirect_en=1, redirect_pc=64'h9 -> PC=9, no f_valid that cycle.
REQ-042 Accept `IRET -> WAIT_RET, imem_req=0 for 5 cycles; redirect_pc=64'h20 -> FETCH at 64'h20.
REQ-043 Accept `IHALT at PC=64'h10 -> stat=1, PC=64'h10, imem_req=0; valid 0 then 1 -> refetch at 64'h10.
REQ-044 dec_inst_valid=0 on accept -> stat=2, no f_valid, inst_cnt unchanged; stall=1 with imem_ack=1 -> no accept, PC unchanged.
REQ-045 inst_cnt preset near all-ones (CNT_WIDTH=4, 15 accepts then 1 more) -> wraps to 0.
